// File: rtl/button_event_fsm.sv
// Turns a debounced button level into one-cycle press/release/short/long/repeat
// pulses, with hold timing counted in ticks of a shared slow strobe.
module button_event_fsm #(
    parameter int unsigned LONG_TICKS   = 8,
    parameter int unsigned REPEAT_TICKS = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_level,
    input  logic       tick,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        HELD    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             press_next, release_next, short_next, long_next, repeat_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            short_pulse   <= short_next;
            long_pulse    <= long_next;
            repeat_pulse  <= repeat_next;
            held          <= (state_next == HELD);
        end
    end

    // Release is tested first in each state so it always beats a terminal tick.
    always_comb begin
        state_next   = state;
        count_next   = count;
        press_next   = 1'b0;
        release_next = 1'b0;
        short_next   = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;
        case (state)
            IDLE: begin
                if (btn_level) begin
                    state_next = PRESSED;
                    count_next = '0;
                    press_next = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_level) begin
                    state_next   = IDLE;
                    count_next   = '0;
                    release_next = 1'b1;
                    short_next   = 1'b1;
                end else if (tick && count == LONG_LAST) begin
                    state_next = HELD;
                    count_next = '0;
                    long_next  = 1'b1;
                end else if (tick) begin
                    count_next = count + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_level) begin
                    state_next   = IDLE;
                    count_next   = '0;
                    release_next = 1'b1;
                end else if (tick && count == REPEAT_LAST) begin
                    count_next  = '0;
                    repeat_next = 1'b1;
                end else if (tick) begin
                    count_next = count + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign state_out = state;

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed-vector bench for button_event_fsm; each vector compares the full
// output set {press,release,short,long,repeat,held,state_out} after an edge.
module tb_button_event_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_level = 1'b0;
    logic       tick = 1'b0;
    logic       press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
    logic [1:0] state_out;
    logic [7:0] obs;
    logic [7:0] exp_v;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    button_event_fsm #(
        .LONG_TICKS(8),
        .REPEAT_TICKS(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_level(btn_level),
        .tick(tick),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .short_pulse(short_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .held(held),
        .state_out(state_out)
    );

    assign obs = {press_pulse, release_pulse, short_pulse, long_pulse,
                  repeat_pulse, held, state_out};

    // Apply inputs, clock once, let outputs settle.
    task automatic edge_in(input logic r, input logic b, input logic t);
        reset     = r;
        btn_level = b;
        tick      = t;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        edge_in(1'b0, 1'b0, 1'b0);
        edge_in(1'b0, 1'b0, 1'b0);
        edge_in(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            edge_in(1'b0, 1'b1, 1'b1);
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_hold[%0d] got %b want %b", i, obs, 8'h00);
            end
        end
        for (int i = 0; i < 2; i++) begin
            edge_in(1'b1, 1'b1, 1'b1);
            exp_v = (i == 0) ? 8'b1000_0001 : 8'b0000_0001;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL reset_release[%0d] got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_short_press();
        go_idle();
        for (int i = 0; i < 5; i++) begin
            edge_in(1'b1, (i < 3), 1'b1);
            case (i)
                0:       exp_v = 8'b1000_0001;
                1, 2:    exp_v = 8'b0000_0001;
                3:       exp_v = 8'b0110_0000;
                default: exp_v = 8'b0000_0000;
            endcase
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL short_press[c%0d] got %b want %b", i + 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_long_repeat();
        int c;
        go_idle();
        for (int i = 0; i < 22; i++) begin
            edge_in(1'b1, (i < 20), 1'b1);
            c = i + 1;
            exp_v = 8'h00;
            if (c == 1)              exp_v[7] = 1'b1;
            if (c == 21)             exp_v[6] = 1'b1;
            if (c == 9)              exp_v[4] = 1'b1;
            if (c == 13 || c == 17)  exp_v[3] = 1'b1;
            if (c >= 9 && c <= 20)   exp_v[2] = 1'b1;
            if (c >= 1 && c <= 8)    exp_v[1:0] = 2'b01;
            if (c >= 9 && c <= 20)   exp_v[1:0] = 2'b10;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL long_repeat[c%0d] got %b want %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_tick_gating();
        int c;
        go_idle();
        // Ticks at edges 0,3,6,...; the one at edge 0 falls on the IDLE
        // transition and is ignored, so the 8th counted tick is at edge 24.
        for (int i = 0; i < 27; i++) begin
            edge_in(1'b1, 1'b1, (i % 3 == 0));
            c = i + 1;
            exp_v = 8'h00;
            if (c == 1)   exp_v[7] = 1'b1;
            if (c == 25)  exp_v[4] = 1'b1;
            if (c >= 25)  exp_v[2] = 1'b1;
            exp_v[1:0] = (c >= 25) ? 2'b10 : 2'b01;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL tick_gating[c%0d] got %b want %b", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_race();
        go_idle();
        for (int i = 0; i < 9; i++) begin
            edge_in(1'b1, (i < 8), 1'b1);
            if (i == 0)      exp_v = 8'b1000_0001;
            else if (i < 8)  exp_v = 8'b0000_0001;
            else             exp_v = 8'b0110_0000;
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL race[c%0d] got %b want %b", i + 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_held();
        go_idle();
        for (int i = 0; i < 9; i++) edge_in(1'b1, 1'b1, 1'b1);
        vectors++;
        if (obs !== 8'b0001_0110) begin
            miscompares++;
            $display("FAIL mid_held_entry got %b want %b", obs, 8'b0001_0110);
        end
        edge_in(1'b0, 1'b1, 1'b1);
        vectors++;
        if (obs !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_held_reset got %b want %b", obs, 8'h00);
        end
        edge_in(1'b1, 1'b1, 1'b1);
        vectors++;
        if (obs !== 8'b1000_0001) begin
            miscompares++;
            $display("FAIL mid_held_repress got %b want %b", obs, 8'b1000_0001);
        end
    endtask

    task automatic test_back_to_back();
        go_idle();
        for (int i = 0; i < 4; i++) begin
            edge_in(1'b1, (i != 1), 1'b1);
            case (i)
                0, 2:    exp_v = 8'b1000_0001;
                1:       exp_v = 8'b0110_0000;
                default: exp_v = 8'b0000_0001;
            endcase
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL back_to_back[c%0d] got %b want %b", i + 1, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_repeat();
        test_tick_gating();
        test_race();
        test_reset_mid_held();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_event_fsm.md
Name: button_event_fsm

Overview:
- Consumes the debounced, clock-synchronous button level from the debounce stage.
- Converts it into single-cycle event pulses: press, release, short-press, long-press and auto-repeat while held.
- Counting advances only on cycles where the `tick` enable is high, so hold times are set by a shared slow strobe rather than the raw clock.
- Feeds mode/menu logic that needs one pulse per user action.

Parameters:
- LONG_TICKS, 8: ticks in PRESSED before a press counts as long; legal range ≥ 1.
- REPEAT_TICKS, 4: ticks between repeat pulses once in HELD; legal range ≥ 1.
- CNT_W, 4: counter width; must satisfy 2^CNT_W ≥ max(LONG_TICKS, REPEAT_TICKS).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
- btn_level  input  1  debounced button level, 1 = pressed; already synchronous to clk.
- tick  input  1  count enable strobe; counter advances only when 1.
- press_pulse  output  1  one-cycle pulse on press.
- release_pulse  output  1  one-cycle pulse on any release.
- short_pulse  output  1  one-cycle pulse on release before the long threshold.
- long_pulse  output  1  one-cycle pulse when the long threshold is reached.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_TICKS ticks while in HELD.
- held  output  1  level, 1 while state==HELD.
- state_out  output  2  current state encoding, for debug.

Behaviour:
- Single clock domain, single synchronous active-low reset. No other clocks, resets or asynchronous paths.
- Reset (reset==0 at a posedge):
  - state=IDLE, counter=0.
  - All pulse outputs=0, held=0.
  - Takes effect regardless of btn_level or tick; a reset mid-HELD or mid-PRESSED emits no release/short pulse.
- Outputs are registered:
  - Each pulse is high for exactly one cycle, the cycle after the condition is sampled.
  - Latency from input condition to pulse is 1 cycle.
- States: IDLE=2'b00, PRESSED=2'b01, HELD=2'b10. The encoding 2'b11 is unreachable and must go to IDLE on the next clock with no pulses.
- IDLE:
  - If btn_level==1: go to PRESSED, counter=0, assert press_pulse.
  - Otherwise stay in IDLE.
  - tick is ignored in IDLE and on the transition cycle.
- PRESSED, priority in this order:
  1. If btn_level==0: go to IDLE, counter=0, assert release_pulse and short_pulse together.
  2. Else if tick==1 and counter==LONG_TICKS-1: go to HELD, counter=0, assert long_pulse.
  3. Else if tick==1: counter+1.
- HELD, priority in this order:
  1. If btn_level==0: go to IDLE, counter=0, assert release_pulse only (no short_pulse).
  2. Else if tick==1 and counter==REPEAT_TICKS-1: stay in HELD, counter=0, assert repeat_pulse.
  3. Else if tick==1: counter+1.
- Simultaneous events: release beats threshold. If btn_level==0 and the terminal tick arrive in the same cycle, only release (+short in PRESSED) fires; no long or repeat pulse.
- Counter behaviour:
  - Never wraps: it is cleared on every transition and on every repeat.
  - Arithmetic is unsigned CNT_W bits.
  - With LONG_TICKS==1 the first tick in PRESSED triggers long.
- Mutual exclusion:
  - press_pulse never coincides with any other pulse.
  - short_pulse and long_pulse never both fire for one press.
- Reset release with btn_level already 1: treated as a fresh press; press_pulse fires 1 cycle after the first non-reset sample.
- held equals (state==HELD), registered; state_out equals state.

Test Plan (defaults, tick=1 constantly unless stated):
- Reset held low 3 cycles with btn_level=1 and tick=1 -> all pulses 0, held=0, state_out=00 throughout; press_pulse at cycle 1 after the reset deasserts.
- Short press: btn_level=1 sampled cycles 0–2, 0 at cycle 3 -> press_pulse at cycle 1; release_pulse and short_pulse both at cycle 4; no long_pulse; state_out=00 at cycle 4.
- Long press with repeat: btn_level=1 from cycle 0 for 20 cycles -> press_pulse cycle 1, long_pulse cycle 9, held=1 from cycle 9, repeat_pulse cycles 13 and 17. On release sampled at cycle 20: release_pulse cycle 21, short_pulse never, held=0 at cycle 21.
- Tick gating: tick=1 only every 3rd cycle, btn_level=1 long -> long_pulse exactly one cycle after the 8th tick sampled in PRESSED; counter frozen on non-tick cycles.
- Race: in PRESSED with counter=7, btn_level=0 and tick=1 sampled the same cycle -> release_pulse and short_pulse next cycle, long_pulse stays 0, state_out=00.
- Reset mid-HELD: reset=0 for one cycle while held=1 -> next cycle state_out=00, held=0, no release_pulse. With btn_level still 1, press_pulse fires one cycle after reset returns high.
